// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers: round-robin grant per byte,
// a byte FIFO, and a start/busy sequencer. Optional macro TXARB_LOCK_EN adds grant locking.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [8*NUM_REQ-1:0]        req_data,
  input  logic [NUM_REQ-1:0]          req_lock,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        full_seen,
  input  logic                        full_seen_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          full_seen_q, full_seen_d;

  logic          fifo_full, push, pop, take_lock;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx, cand;
  logic          lock_active;
  logic [IW-1:0] lock_owner;

`ifdef TXARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_owner_q, lock_owner_d;

  assign take_lock   = push && req_lock[gnt_idx];
  assign lock_active = lock_q;
  assign lock_owner  = lock_owner_q;

  // Every byte from the granted requester decides whether the lock stays on.
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (push) begin
      lock_d       = req_lock[gnt_idx];
      lock_owner_d = gnt_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign take_lock   = 1'b0;
  assign lock_active = 1'b0;
  assign lock_owner  = '0;
`endif

  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));

  // Descending scan so the last hit is the requester closest to rr going upward.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (!fifo_full) begin
      if (lock_active) begin
        gnt_valid = req_valid[lock_owner];
        gnt_idx   = lock_owner;
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          cand = IW'((int'(rr_q) + k) % NUM_REQ);
          if (req_valid[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_valid) req_ready[gnt_idx] = 1'b1;
  end

  assign push = gnt_valid;
  assign pop  = (state_q == S_IDLE) && (count_q != '0) && !tx_busy;

  always_comb begin
    rr_d = rr_q;
    if (push && !take_lock) rr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Set has priority over clear so a hold-off in the clearing cycle is not lost.
  always_comb begin
    full_seen_d = full_seen_q;
    if ((|req_valid) && fifo_full) full_seen_d = 1'b1;
    else if (full_seen_clear)      full_seen_d = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d    = S_WAIT_ACK;
          timer_d    = '0;
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy)                              state_d = S_WAIT_DONE;
        else if (timer_q == TW'(ACK_TIMEOUT - 1)) state_d = S_IDLE;
        else                                      timer_d = timer_q + 1'b1;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      full_seen_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      rr_q        <= rr_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      full_seen_q <= full_seen_d;
    end
  end

  // NOTE: the byte storage is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= req_data[8*gnt_idx +: 8];
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign full_seen  = full_seen_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a queue-based behavioural model,
// with an emulated transmitter that answers start pulses with a busy window.
module tb_uart_tx_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 16;
  localparam int TMO   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [8*N-1:0]  req_data = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N-1:0]    req_ready;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy = 1'b0;
  logic [CW-1:0]   fifo_count;
  logic            full_seen;
  logic            full_seen_clear = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .fifo_count(fifo_count), .full_seen(full_seen),
    .full_seen_clear(full_seen_clear)
  );

  always #5 clock = ~clock;

  // Behavioural model: byte queue, round-robin pointer, lock owner, and the transmit
  // handshake phase (0 free, 1 awaiting busy, 2 transmitter sending).
  byte unsigned m_q[$];
  int           m_rr = 0;
  bit           m_lock = 0;
  int           m_owner = 0;
  bit           m_fs = 0;
  bit           m_start = 0;
  logic [7:0]   m_data = '0;
  int           m_phase = 0;
  int           m_wait = 0;

  // Transmitter emulation: 0 responsive, 1 stuck busy, 2 never busy.
  int u_mode = 0, u_t = -1, u_delay = 2, u_len = 2;
  bit u_rand = 0;
  logic [7:0] got[$];

  function automatic int m_grant();
    if (m_q.size() == DEPTH) return -1;
    if (m_lock) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    g = m_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic settle();
    @(negedge clock);
    if (tx_start === 1'b1) got.push_back(tx_data);
  endtask

  task automatic advance();
    int g;
    bit pop;
    g = m_grant();
    if (reset) begin
      m_q.delete();
      m_rr = 0; m_lock = 0; m_owner = 0; m_fs = 0;
      m_start = 0; m_data = '0; m_phase = 0; m_wait = 0;
    end else begin
      pop = (m_phase == 0) && (m_q.size() > 0) && !tx_busy;
      if ((|req_valid) && m_q.size() == DEPTH) m_fs = 1;
      else if (full_seen_clear)                m_fs = 0;
      m_start = pop;
      if (pop) begin
        m_data = m_q.pop_front(); m_phase = 1; m_wait = 0;
      end else if (m_phase == 1) begin
        if (tx_busy)              m_phase = 2;
        else if (m_wait == TMO-1) m_phase = 0;
        else                      m_wait++;
      end else if (m_phase == 2 && !tx_busy) begin
        m_phase = 0;
      end
      if (g >= 0) begin
        m_q.push_back(req_data[8*g +: 8]);
`ifdef TXARB_LOCK_EN
        if (req_lock[g]) begin m_lock = 1; m_owner = g; end
        else begin m_lock = 0; m_rr = (g + 1) % N; end
`else
        m_rr = (g + 1) % N;
`endif
      end
    end
    @(posedge clock);
    #1;
    case (u_mode)
      0: begin
        if (tx_start === 1'b1) begin
          u_t = 0;
          if (u_rand) begin u_delay = $urandom_range(1, 6); u_len = $urandom_range(1, 4); end
        end else if (u_t >= 0) u_t++;
        tx_busy = (u_t >= u_delay) && (u_t < u_delay + u_len);
        if (u_t >= u_delay + u_len) u_t = -1;
      end
      1:       tx_busy = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  endtask

  task automatic do_reset(input int mode);
    u_mode = mode; u_t = -1; u_rand = 0;
    tx_busy = (mode == 1);
    reset = 1'b1; req_valid = '0; req_lock = '0; full_seen_clear = 1'b0;
    settle();
    advance();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset(0);
    settle();
    vectors += 5;
    if (fifo_count !== '0) begin miscompares++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b want 0", tx_start); end
    if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", tx_data); end
    if (full_seen !== 1'b0) begin miscompares++; $display("FAIL reset_full_seen got %b want 0", full_seen); end
    if (req_ready !== '0) begin miscompares++; $display("FAIL reset_ready_idle got %b want 00", req_ready); end
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL reset_rr_start got %b want 01", req_ready); end
    req_valid = '0;
    advance();
  endtask

  task automatic test_single();
    int acc_c = -1, st_c = -1;
    do_reset(0);
    u_delay = 10; u_len = 3;
    req_valid = 2'b01; req_data = {8'h00, 8'h41};
    for (int c = 0; c < 40; c++) begin
      settle();
      vectors += 4;
      if (req_ready !== m_ready()) begin miscompares++; $display("FAIL single_ready c%0d got %b want %b", c, req_ready, m_ready()); end
      if (fifo_count !== CW'(m_q.size())) begin miscompares++; $display("FAIL single_count c%0d got %0d want %0d", c, fifo_count, m_q.size()); end
      if (tx_start !== m_start) begin miscompares++; $display("FAIL single_start c%0d got %b want %b", c, tx_start, m_start); end
      if (tx_data !== m_data) begin miscompares++; $display("FAIL single_data c%0d got %h want %h", c, tx_data, m_data); end
      if (acc_c < 0 && req_valid[0] && req_ready[0]) acc_c = c;
      if (st_c < 0 && tx_start === 1'b1) st_c = c;
      advance();
      if (acc_c >= 0) req_valid = '0;
    end
    vectors += 3;
    if (st_c - acc_c != 2) begin miscompares++; $display("FAIL single_latency got %0d want 2", st_c - acc_c); end
    if (fifo_count !== '0) begin miscompares++; $display("FAIL single_drained got %0d want 0", fifo_count); end
    if (got.size() != 1 || got[0] !== 8'h41) begin miscompares++; $display("FAIL single_byte got %0d bytes want one 41", got.size()); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] dg[$];
    do_reset(0);
    u_delay = 2; u_len = 2;
    req_valid = 2'b11; req_data = {8'hB0, 8'hA0};
    for (int c = 0; c < 60; c++) begin
      settle();
      vectors += 5;
      if (req_ready !== m_ready()) begin miscompares++; $display("FAIL rr_ready c%0d got %b want %b", c, req_ready, m_ready()); end
      if (fifo_count !== CW'(m_q.size())) begin miscompares++; $display("FAIL rr_count c%0d got %0d want %0d", c, fifo_count, m_q.size()); end
      if (tx_start !== m_start) begin miscompares++; $display("FAIL rr_start c%0d got %b want %b", c, tx_start, m_start); end
      if (tx_data !== m_data) begin miscompares++; $display("FAIL rr_data c%0d got %h want %h", c, tx_data, m_data); end
      if (full_seen !== m_fs) begin miscompares++; $display("FAIL rr_full_seen c%0d got %b want %b", c, full_seen, m_fs); end
      if (|(req_valid & req_ready)) dg.push_back(req_ready);
      advance();
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      vectors += 2;
      if (i >= dg.size() || dg[i] !== ((i % 2) ? 2'b10 : 2'b01)) begin
        miscompares++; $display("FAIL rr_grant_order idx %0d got %b want %b", i, (i < dg.size()) ? dg[i] : 2'bxx, (i % 2) ? 2'b10 : 2'b01);
      end
      if (i >= got.size() || got[i] !== ((i % 2) ? 8'hB0 : 8'hA0)) begin
        miscompares++; $display("FAIL rr_byte_order idx %0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, (i % 2) ? 8'hB0 : 8'hA0);
      end
    end
  endtask

  task automatic test_full();
    int acc_n = 0;
    bit acc;
    do_reset(1);
    req_valid = 2'b01; req_data[7:0] = 8'($urandom);
    for (int c = 0; c < 17; c++) begin
      settle();
      vectors += 3;
      if (req_ready !== m_ready()) begin miscompares++; $display("FAIL full_ready c%0d got %b want %b", c, req_ready, m_ready()); end
      if (fifo_count !== CW'(m_q.size())) begin miscompares++; $display("FAIL full_count c%0d got %0d want %0d", c, fifo_count, m_q.size()); end
      if (full_seen !== m_fs) begin miscompares++; $display("FAIL full_seen_track c%0d got %b want %b", c, full_seen, m_fs); end
      if (c == 16) begin
        vectors++;
        if (req_ready !== 2'b00) begin miscompares++; $display("FAIL full_holdoff got %b want 00", req_ready); end
      end
      acc = req_valid[0] && req_ready[0];
      if (acc) acc_n++;
      advance();
      if (acc) req_data[7:0] = 8'($urandom);
    end
    settle();
    vectors += 3;
    if (acc_n != 16) begin miscompares++; $display("FAIL full_accepted got %0d want 16", acc_n); end
    if (full_seen !== 1'b1) begin miscompares++; $display("FAIL full_seen_set got %b want 1", full_seen); end
    if (fifo_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL full_count_max got %0d want %0d", fifo_count, DEPTH); end
    req_valid = '0; full_seen_clear = 1'b1;
    advance();
    full_seen_clear = 1'b0;
    settle();
    vectors++;
    if (full_seen !== 1'b0) begin miscompares++; $display("FAIL full_seen_clear got %b want 0", full_seen); end
    req_valid = 2'b01; full_seen_clear = 1'b1;
    advance();
    req_valid = '0; full_seen_clear = 1'b0;
    settle();
    vectors++;
    if (full_seen !== 1'b1) begin miscompares++; $display("FAIL full_set_beats_clear got %b want 1", full_seen); end
    advance();
  endtask

  task automatic test_timeout();
    logic [7:0] sent[$];
    int starts[$];
    int n = 0;
    bit acc;
    do_reset(2);
    req_valid = 2'b10; req_data[15:8] = 8'($urandom);
    for (int c = 0; c < 30; c++) begin
      settle();
      vectors += 3;
      if (req_ready !== m_ready()) begin miscompares++; $display("FAIL tmo_ready c%0d got %b want %b", c, req_ready, m_ready()); end
      if (tx_start !== m_start) begin miscompares++; $display("FAIL tmo_start c%0d got %b want %b", c, tx_start, m_start); end
      if (tx_data !== m_data) begin miscompares++; $display("FAIL tmo_data c%0d got %h want %h", c, tx_data, m_data); end
      if (tx_start === 1'b1) starts.push_back(c);
      acc = req_valid[1] && req_ready[1];
      if (acc) begin sent.push_back(req_data[15:8]); n++; end
      advance();
      if (acc) begin
        if (n == 3) req_valid = '0;
        else        req_data[15:8] = 8'($urandom);
      end
    end
    vectors++;
    if (starts.size() != 3) begin
      miscompares++; $display("FAIL tmo_start_count got %0d want 3", starts.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (starts[i] - starts[i-1] != TMO + 1) begin
          miscompares++; $display("FAIL tmo_spacing idx %0d got %0d want %0d", i, starts[i] - starts[i-1], TMO + 1);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== sent[i]) begin
        miscompares++; $display("FAIL tmo_bytes idx %0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, sent[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit hit = 0, acc;
    do_reset(0);
    u_delay = 1; u_len = 40;
    req_valid = 2'b01; req_data[7:0] = 8'($urandom);
    for (int c = 0; c < 40 && !hit; c++) begin
      settle();
      acc = req_valid[0] && req_ready[0];
      advance();
      if (acc) begin
        n++;
        if (n == 6) req_valid = '0;
        else        req_data[7:0] = 8'($urandom);
      end
      if (m_phase == 2 && m_q.size() == 5) hit = 1;
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL midrst_reach_wait_done got 0 want 1"); end
    reset = 1'b1; req_valid = 2'b11;
    settle();
    advance();
    reset = 1'b0;
    settle();
    vectors += 4;
    if (fifo_count !== '0) begin miscompares++; $display("FAIL midrst_count got %0d want 0", fifo_count); end
    if (tx_start !== 1'b0) begin miscompares++; $display("FAIL midrst_start got %b want 0", tx_start); end
    if (tx_data !== 8'h00) begin miscompares++; $display("FAIL midrst_data got %h want 00", tx_data); end
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL midrst_ready got %b want 01", req_ready); end
    req_valid = '0;
    advance();
  endtask

  task automatic test_random();
    logic [N-1:0] acc;
    int pct;
    do_reset(0);
    u_rand = 1;
    for (int c = 0; c < 600; c++) begin
      settle();
      vectors += 5;
      if (req_ready !== m_ready()) begin miscompares++; $display("FAIL rnd_ready c%0d got %b want %b", c, req_ready, m_ready()); end
      if (fifo_count !== CW'(m_q.size())) begin miscompares++; $display("FAIL rnd_count c%0d got %0d want %0d", c, fifo_count, m_q.size()); end
      if (tx_start !== m_start) begin miscompares++; $display("FAIL rnd_start c%0d got %b want %b", c, tx_start, m_start); end
      if (tx_data !== m_data) begin miscompares++; $display("FAIL rnd_data c%0d got %h want %h", c, tx_data, m_data); end
      if (full_seen !== m_fs) begin miscompares++; $display("FAIL rnd_full_seen c%0d got %b want %b", c, full_seen, m_fs); end
      acc = req_valid & req_ready;
      advance();
      pct = (c < 300) ? 10 : 60;
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !acc[i])) begin
          req_valid[i]       = ($urandom_range(0, 99) < pct);
          req_data[8*i +: 8] = 8'($urandom);
          req_lock[i]        = 1'($urandom_range(0, 1));
        end
      end
      full_seen_clear = ($urandom_range(0, 9) == 0);
    end
    req_valid = '0; req_lock = '0; full_seen_clear = 1'b0;
  endtask

`ifdef TXARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] dg[$];
    int n0 = 0;
    bit acc0;
    do_reset(1);
    req_valid = 2'b11; req_data = {8'hB1, 8'hA1}; req_lock = 2'b01;
    for (int c = 0; c < 6; c++) begin
      settle();
      vectors++;
      if (req_ready !== m_ready()) begin miscompares++; $display("FAIL lock_ready c%0d got %b want %b", c, req_ready, m_ready()); end
      if (|(req_valid & req_ready)) dg.push_back(req_ready);
      acc0 = req_valid[0] && req_ready[0];
      advance();
      if (acc0) begin
        n0++;
        if (n0 == 3) req_valid[0] = 1'b0;
        req_lock[0] = (n0 < 2);
      end
    end
    req_valid = '0; req_lock = '0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= dg.size() || dg[i] !== ((i < 3) ? 2'b01 : 2'b10)) begin
        miscompares++; $display("FAIL lock_grant_order idx %0d got %b want %b", i, (i < dg.size()) ? dg[i] : 2'bxx, (i < 3) ? 2'b01 : 2'b10);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_timeout();
    test_reset_mid();
`ifdef TXARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte producers, e.g. the CPU output port and a debug/status source. The block arbitrates round-robin per byte and buffers accepted bytes in an internal FIFO. A small FSM sequences each buffered byte into the transmitter using a start/busy handshake. It sits between the producers and uart_tx in the board top level.

Parameters:
NUM_REQ, 2, number of requesters (≥1)
FIFO_DEPTH, 16, buffered bytes; power of two, ≥2
ACK_TIMEOUT, 4, cycles to wait for tx_busy to rise after a start pulse (≥1)

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_lock  input  NUM_REQ  hold-grant request; used only with TXARB_LOCK_EN
req_ready  output  NUM_REQ  one-hot-or-zero grant; a transfer happens when valid&ready
tx_data  output  8  byte presented to the transmitter
tx_start  output  1  one-cycle start pulse to the transmitter
tx_busy  input  1  transmitter busy
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
full_seen  output  1  sticky: a valid byte was held off because the FIFO was full
full_seen_clear  input  1  clears full_seen

Behaviour:
- Reset (synchronous, active-high): FIFO empty, fifo_count=0, rr pointer=0, FSM=IDLE, tx_start=0, tx_data=0, full_seen=0, lock released.
- Reset mid-transmission flushes the FIFO and drops tx_start. The transmitter itself is not reset by this block.
- Arbitration (combinational):
  - If fifo_count<FIFO_DEPTH, grant the first requester with req_valid=1 scanning from rr upward, modulo NUM_REQ.
  - Only that requester sees req_ready=1.
  - If the FIFO is full, all req_ready=0. There is no write bypass on a same-cycle pop.
- After a transfer from requester g, rr=(g+1) mod NUM_REQ. With no transfer, rr holds.
- Requesters must not make valid depend on ready. A requester holds data stable while valid=1 and ready=0.
- FIFO:
  - A push is written at the accepting edge, so fifo_count is visible +1 on the next cycle.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- full_seen:
  - Set when any req_valid=1 while fifo_count==FIFO_DEPTH.
  - Cleared by full_seen_clear. If set and clear occur in the same cycle, set wins.
- Sequencer FSM, registered outputs:
  - IDLE: if fifo_count>0 and tx_busy=0, then at the edge register tx_data=FIFO head, tx_start=1, pop, and go to WAIT_ACK.
  - WAIT_ACK: tx_start=0 after one cycle. On tx_busy=1 go to WAIT_DONE. After ACK_TIMEOUT cycles without busy, go to IDLE.
  - WAIT_DONE: on tx_busy=0 go to IDLE.
  - tx_data is held stable from the start pulse until the FSM re-enters IDLE.
- Latency: a byte accepted at edge E0 into an empty FIFO with an idle transmitter has tx_start high in the cycle following edge E1.
- Back-to-back bytes: a new start is issued no earlier than the cycle after the FSM re-enters IDLE.
- tx_start is never asserted while tx_busy=1 is sampled in IDLE.

Optional Feature:
TXARB_LOCK_EN
- Defined:
  - A transfer from requester g with req_lock[g]=1 locks the grant to g.
  - While locked, only g may receive req_ready, and the rr pointer is frozen.
  - The lock releases after a transfer from g with req_lock[g]=0; rr then advances to g+1.
  - Reset releases the lock.
  - A locked requester that drops valid stalls all others. This is intended, so multi-byte messages are never interleaved.
- Undefined: req_lock is ignored and arbitration is round-robin per byte.

Test Plan:
- Reset, then req0 sends 0x41 with an idle transmitter (tx_busy pulses high 10 cycles after start) -> tx_start 1 cycle high one edge after acceptance, tx_data=0x41, fifo_count returns to 0.
- req0 and req1 valid continuously with 0xA0/0xB0 -> grants alternate 0,1,0,1; UART byte order A0,B0,A0,B0.
- Hold tx_busy=1 and push 17 bytes from req0 with FIFO_DEPTH=16 -> 16 accepted, req_ready=0 on the 17th, full_seen=1; after a clear pulse full_seen=0; assert clear and a full hold-off in the same cycle -> full_seen stays 1.
- Transmitter never raises tx_busy -> FSM returns to IDLE after ACK_TIMEOUT=4 cycles and the next byte starts.
- Assert reset while in WAIT_DONE with 5 bytes queued -> next cycle fifo_count=0, tx_start=0, req_ready reflects the empty FIFO.
- With TXARB_LOCK_EN: req0 sends 3 bytes with lock=1,1,0 while req1 is valid -> req1 is granted only after the third req0 byte.
